ex_stage: RTL and testbench

- Execute stage of the 16-bit pipelined core. It sits directly downstream of decode/register-read and consumes the registered forwarding selects from the hazard unit.
- Contains the ID/EX pipeline register, the operand-forwarding muxes, the ALU, branch resolution and the EX/MEM pipeline register.
- Its registered ALU result is the "hot" forwarding source that feeds back to the hazard unit.

---
 rtl/ex_stage.sv | 179 +++++++++++++++++
 tb/tb_ex_stage.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// Execute stage: ID/EX register, operand forwarding, ALU, branch resolution and EX/MEM register.
// The registered ALU result doubles as the hot forwarding source back to the hazard unit.
module ex_stage #(
   parameter int unsigned DW        = 16,
   parameter logic [15:0] NOP_INSTR = 16'h7000
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          id_valid,
   input  logic [15:0]   id_instr,
   input  logic [15:0]   id_pc,
   input  logic [DW-1:0] id_rs_data,
   input  logic [DW-1:0] id_rt_data,
   input  logic [1:0]    fw_op1_sel,
   input  logic [1:0]    fw_op2_sel,
   input  logic [DW-1:0] fw_cold_data,
   input  logic          stall,
   input  logic          flush,
   output logic          ex_valid,
   output logic [DW-1:0] ex_alu_res,
   output logic [DW-1:0] ex_store_data,
   output logic [2:0]    ex_rd_addr,
   output logic          ex_reg_we,
   output logic          ex_mem_re,
   output logic          ex_mem_we,
   output logic          branch_taken,
   output logic [15:0]   branch_target
);

   localparam logic [3:0] OpR    = 4'd0;
   localparam logic [3:0] OpAddi = 4'd1;
   localparam logic [3:0] OpSlti = 4'd3;
   localparam logic [3:0] OpLw   = 4'd4;
   localparam logic [3:0] OpSw   = 4'd5;
   localparam logic [3:0] OpBeq  = 4'd6;

   // ID/EX pipeline register
   logic          idex_valid_q;
   logic [15:0]   idex_instr_q;
   logic [15:0]   idex_pc_q;
   logic [DW-1:0] idex_rs_q;
   logic [DW-1:0] idex_rt_q;

   logic [3:0]    opcode;
   logic [2:0]    f_rs, f_rt, f_rd, funct;
   logic [5:0]    imm6;
   logic [DW-1:0] imm_sext;
   logic [15:0]   imm_sext16;
   logic [DW-1:0] op_a, op_b;
   logic [DW-1:0] alu_res;
   logic [2:0]    dest;
   logic          writes_reg, is_load, is_store, is_beq;
   logic          ex_live, br_fire;

   assign opcode     = idex_instr_q[15:12];
   assign f_rs       = idex_instr_q[11:9];
   assign f_rt       = idex_instr_q[8:6];
   assign f_rd       = idex_instr_q[5:3];
   assign funct      = idex_instr_q[2:0];
   assign imm6       = idex_instr_q[5:0];
   assign imm_sext   = {{(DW-6){imm6[5]}}, imm6};
   assign imm_sext16 = {{10{imm6[5]}}, imm6};

   always_comb begin
      op_a = idex_rs_q;
      unique case (fw_op1_sel)
         2'd1:    op_a = ex_alu_res;
         2'd2:    op_a = fw_cold_data;
         default: op_a = idex_rs_q;
      endcase
   end

   always_comb begin
      op_b = idex_rt_q;
      unique case (fw_op2_sel)
         2'd1:    op_b = ex_alu_res;
         2'd2:    op_b = fw_cold_data;
         default: op_b = idex_rt_q;
      endcase
   end

   always_comb begin
      alu_res    = '0;
      dest       = 3'd0;
      writes_reg = 1'b0;
      is_load    = 1'b0;
      is_store   = 1'b0;
      is_beq     = 1'b0;
      case (opcode)
         OpR: begin
            dest       = f_rd;
            writes_reg = 1'b1;
            unique case (funct)
               3'd0: alu_res = op_a + op_b;
               3'd1: alu_res = op_a - op_b;
               3'd2: alu_res = op_a & op_b;
               3'd3: alu_res = op_a | op_b;
               3'd4: alu_res = op_a ^ op_b;
               3'd5: alu_res = {{(DW-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
               3'd6: alu_res = op_a << op_b[3:0];
               3'd7: alu_res = op_a >> op_b[3:0];
               default: alu_res = '0;
            endcase
         end
         OpAddi: begin
            alu_res    = op_b + imm_sext;
            dest       = f_rs;
            writes_reg = 1'b1;
         end
         OpSlti: begin
            alu_res    = {{(DW-1){1'b0}}, ($signed(op_b) < $signed(imm_sext))};
            dest       = f_rs;
            writes_reg = 1'b1;
         end
         OpLw: begin
            alu_res    = op_a + imm_sext;
            dest       = f_rt;
            writes_reg = 1'b1;
            is_load    = 1'b1;
         end
         OpSw: begin
            alu_res  = op_a + imm_sext;
            is_store = 1'b1;
         end
         OpBeq: begin
            is_beq = 1'b1;
         end
         default: ;
      endcase
   end

   assign ex_live = idex_valid_q && !stall;
   // A stalled beq is neither reported nor self-flushed, so it resolves once the stall drops.
   assign br_fire = ex_live && is_beq && (op_a == op_b);

   always_ff @(posedge clk) begin
      if (rst || flush || br_fire) begin
         idex_valid_q <= 1'b0;
         idex_instr_q <= NOP_INSTR;
         idex_pc_q    <= '0;
         idex_rs_q    <= '0;
         idex_rt_q    <= '0;
      end else if (!stall) begin
         idex_valid_q <= id_valid;
         idex_instr_q <= id_valid ? id_instr : NOP_INSTR;
         idex_pc_q    <= id_valid ? id_pc : '0;
         idex_rs_q    <= id_valid ? id_rs_data : '0;
         idex_rt_q    <= id_valid ? id_rt_data : '0;
      end
   end

   // Data fields hold across bubbles so the hot forward stays stable.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid      <= 1'b0;
         ex_alu_res    <= '0;
         ex_store_data <= '0;
         ex_rd_addr    <= 3'd0;
         ex_reg_we     <= 1'b0;
         ex_mem_re     <= 1'b0;
         ex_mem_we     <= 1'b0;
         branch_taken  <= 1'b0;
         branch_target <= '0;
      end else begin
         ex_valid     <= ex_live;
         ex_reg_we    <= ex_live && writes_reg && (dest != 3'd0);
         ex_mem_re    <= ex_live && is_load;
         ex_mem_we    <= ex_live && is_store;
         branch_taken <= br_fire;
         if (ex_live) begin
            ex_alu_res    <= alu_res;
            ex_store_data <= op_b;
            ex_rd_addr    <= dest;
            branch_target <= idex_pc_q + 16'd1 + imm_sext16;
         end
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// Directed, table-driven bench for ex_stage plus hand-written branch/stall/flush/reset sequences.
module tb_ex_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid;
   logic [15:0] id_instr, id_pc, id_rs_data, id_rt_data, fw_cold_data;
   logic [1:0]  fw_op1_sel, fw_op2_sel;
   logic        stall, flush;
   logic        ex_valid, ex_reg_we, ex_mem_re, ex_mem_we, branch_taken;
   logic [15:0] ex_alu_res, ex_store_data, branch_target;
   logic [2:0]  ex_rd_addr;

   int checks = 0;
   int errors = 0;

   ex_stage #(.DW(16), .NOP_INSTR(16'h7000)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .fw_op1_sel(fw_op1_sel),
      .fw_op2_sel(fw_op2_sel), .fw_cold_data(fw_cold_data), .stall(stall), .flush(flush),
      .ex_valid(ex_valid), .ex_alu_res(ex_alu_res), .ex_store_data(ex_store_data),
      .ex_rd_addr(ex_rd_addr), .ex_reg_we(ex_reg_we), .ex_mem_re(ex_mem_re),
      .ex_mem_we(ex_mem_we), .branch_taken(branch_taken), .branch_target(branch_target)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [15:0] instr;
      logic [15:0] rs;
      logic [15:0] rt;
      logic [1:0]  s1;
      logic [1:0]  s2;
      logic [15:0] cold;
      logic [15:0] res;
      logic [2:0]  rd;
      logic        we;
      logic        re;
      logic        mwe;
   } vec_t;

   vec_t vecs[16];

   function automatic vec_t mk(string name, logic [15:0] instr, logic [15:0] rs, logic [15:0] rt,
                               logic [1:0] s1, logic [1:0] s2, logic [15:0] cold,
                               logic [15:0] res, logic [2:0] rd, logic we, logic re, logic mwe);
      vec_t v;
      v.name = name; v.instr = instr; v.rs = rs; v.rt = rt; v.s1 = s1; v.s2 = s2;
      v.cold = cold; v.res = res; v.rd = rd; v.we = we; v.re = re; v.mwe = mwe;
      return v;
   endfunction

   task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(logic v, logic [15:0] instr, logic [15:0] rs, logic [15:0] rt);
      id_valid = v; id_instr = instr; id_pc = 16'd0; id_rs_data = rs; id_rt_data = rt;
   endtask

   task automatic idle();
      drive(1'b0, 16'h7000, 16'd0, 16'd0);
      fw_op1_sel = 2'd0; fw_op2_sel = 2'd0;
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0; fw_cold_data = 16'd0;
      idle();

      //                name         instr     rs        rt        s1 s2 cold      res       rd we re mwe
      vecs[0]  = mk("addi_r1",  16'h1205, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0005, 1, 1, 0, 0);
      vecs[1]  = mk("add_hot",  16'h0298, 16'h0000, 16'h0007, 1, 0, 16'h0000, 16'h000C, 3, 1, 0, 0);
      vecs[2]  = mk("add_cold", 16'h0298, 16'h0000, 16'h0007, 2, 0, 16'h0009, 16'h0010, 3, 1, 0, 0);
      vecs[3]  = mk("sub",      16'h0299, 16'h0003, 16'h0005, 0, 0, 16'h0000, 16'hFFFE, 3, 1, 0, 0);
      vecs[4]  = mk("slt",      16'h029D, 16'hFFFE, 16'h0001, 0, 0, 16'h0000, 16'h0001, 3, 1, 0, 0);
      vecs[5]  = mk("sll",      16'h029E, 16'h0001, 16'h0004, 0, 0, 16'h0000, 16'h0010, 3, 1, 0, 0);
      vecs[6]  = mk("addi_m1",  16'h123F, 16'h0000, 16'h0064, 0, 0, 16'h0000, 16'h0063, 1, 1, 0, 0);
      vecs[7]  = mk("sw",       16'h5282, 16'h0100, 16'h0000, 0, 2, 16'hABCD, 16'h0102, 0, 0, 0, 1);
      vecs[8]  = mk("lw",       16'h437F, 16'h0020, 16'h0000, 0, 0, 16'h0000, 16'h001F, 5, 1, 1, 0);
      vecs[9]  = mk("addi_r0",  16'h1003, 16'h0000, 16'h0004, 0, 0, 16'h0000, 16'h0007, 0, 0, 0, 0);
      vecs[10] = mk("xor",      16'h029C, 16'hF0F0, 16'hFF00, 0, 0, 16'h0000, 16'h0FF0, 3, 1, 0, 0);
      vecs[11] = mk("and",      16'h029A, 16'hF0F0, 16'hFF00, 0, 0, 16'h0000, 16'hF000, 3, 1, 0, 0);
      vecs[12] = mk("or",       16'h029B, 16'hF0F0, 16'hFF00, 0, 0, 16'h0000, 16'hFFF0, 3, 1, 0, 0);
      vecs[13] = mk("srl",      16'h029F, 16'h8000, 16'h0003, 0, 0, 16'h0000, 16'h1000, 3, 1, 0, 0);
      vecs[14] = mk("slti",     16'h343F, 16'h0000, 16'hFFFE, 0, 0, 16'h0000, 16'h0001, 2, 1, 0, 0);
      vecs[15] = mk("sel3_rf",  16'h0298, 16'h0002, 16'h0003, 3, 3, 16'h1111, 16'h0005, 3, 1, 0, 0);

      step(); step();
      chk("rst_valid", {15'd0, ex_valid}, 16'd0);
      chk("rst_res", ex_alu_res, 16'd0);
      chk("rst_we", {13'd0, ex_reg_we, ex_mem_re, ex_mem_we}, 16'd0);
      chk("rst_br", {15'd0, branch_taken}, 16'd0);
      rst = 1'b0;

      for (int i = 0; i < 16; i++) begin
         drive(1'b1, vecs[i].instr, vecs[i].rs, vecs[i].rt);
         step();
         idle();
         fw_op1_sel = vecs[i].s1; fw_op2_sel = vecs[i].s2; fw_cold_data = vecs[i].cold;
         step();
         chk({vecs[i].name, "_valid"}, {15'd0, ex_valid}, 16'd1);
         chk({vecs[i].name, "_res"}, ex_alu_res, vecs[i].res);
         chk({vecs[i].name, "_rd"}, {13'd0, ex_rd_addr}, {13'd0, vecs[i].rd});
         chk({vecs[i].name, "_en"}, {13'd0, ex_reg_we, ex_mem_re, ex_mem_we},
             {13'd0, vecs[i].we, vecs[i].re, vecs[i].mwe});
         if (vecs[i].mwe) chk({vecs[i].name, "_store"}, ex_store_data, vecs[i].cold);
      end

      // Opcode 7 with valid set: propagates valid, no enables.
      drive(1'b1, 16'h7000, 16'h1234, 16'h5678);
      step(); idle(); step();
      chk("nop_valid", {15'd0, ex_valid}, 16'd1);
      chk("nop_en", {12'd0, ex_reg_we, ex_mem_re, ex_mem_we, branch_taken}, 16'd0);

      // beq taken: pc=10, imm=-3 -> target 8; the following instruction is discarded.
      drive(1'b1, 16'h62BD, 16'h0007, 16'h0007);
      id_pc = 16'd10;
      step();
      drive(1'b1, 16'h1205, 16'h0000, 16'h0000);
      step();
      chk("beq_taken", {15'd0, branch_taken}, 16'd1);
      chk("beq_target", branch_target, 16'd8);
      chk("beq_res", ex_alu_res, 16'd0);
      chk("beq_we", {13'd0, ex_reg_we, ex_mem_re, ex_mem_we}, 16'd0);
      idle();
      step();
      chk("beq_pulse", {15'd0, branch_taken}, 16'd0);
      chk("beq_bubble", {15'd0, ex_valid}, 16'd0);

      // beq not taken
      drive(1'b1, 16'h62BD, 16'h0007, 16'h0008);
      step(); idle(); step();
      chk("beq_nt", {15'd0, branch_taken}, 16'd0);

      // Back-to-back with a two-cycle stall.
      drive(1'b1, 16'h1201, 16'h0000, 16'd10);
      step();
      drive(1'b1, 16'h1402, 16'h0000, 16'd20);
      step();
      chk("b2b_first", ex_alu_res, 16'd11);
      chk("b2b_first_v", {15'd0, ex_valid}, 16'd1);
      drive(1'b1, 16'h1603, 16'h0000, 16'd30);
      stall = 1'b1;
      for (int k = 0; k < 2; k++) begin
         step();
         chk("stall_bubble", {14'd0, ex_valid, ex_reg_we}, 16'd0);
         chk("stall_hold", ex_alu_res, 16'd11);
      end
      stall = 1'b0;
      step();
      chk("stall_resume", ex_alu_res, 16'd22);
      chk("stall_resume_rd", {13'd0, ex_rd_addr}, 16'd2);
      idle();
      step();
      chk("stall_next", ex_alu_res, 16'd33);
      chk("stall_next_rd", {13'd0, ex_rd_addr}, 16'd3);

      // flush + stall together: bubble everywhere, instruction lost.
      drive(1'b1, 16'h1205, 16'h0000, 16'h0000);
      step();
      idle();
      flush = 1'b1; stall = 1'b1;
      step();
      chk("fs_bubble", {15'd0, ex_valid}, 16'd0);
      flush = 1'b0; stall = 1'b0;
      step();
      chk("fs_lost", {15'd0, ex_valid}, 16'd0);
      chk("fs_res_hold", ex_alu_res, 16'd33);

      // Reset while stalled.
      drive(1'b1, 16'h1205, 16'h0000, 16'h0000);
      step();
      stall = 1'b1; rst = 1'b1;
      step();
      chk("rst_stall_res", ex_alu_res, 16'd0);
      chk("rst_stall_v", {15'd0, ex_valid}, 16'd0);
      rst = 1'b0; stall = 1'b0; idle();
      step();
      chk("rst_stall_cleared", {15'd0, ex_valid}, 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
